axi_mem_slave: RTL and testbench



---
 rtl/axi_mem_slave.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory: one single-port byte-writable array serving one burst at a time.
// Optional WRAP burst support is enabled by defining AXI_MEM_WRAP_EN.
module axi_mem_slave #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int DEPTH_LOG2 = 12,
   parameter int ID_W       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready,
   output logic [1:0]          o_dbg_state
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_HI = DEPTH_LOG2 + LSB;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
`ifdef AXI_MEM_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WR, S_WR_RESP, S_RD} state_t;

   state_t               r_state, w_next;
   logic [ID_W-1:0]      r_id;
   logic [ADDR_W-1:0]    r_addr;
   logic [7:0]           r_len, r_cnt;
   logic [2:0]           r_size;
   logic [1:0]           r_burst;
   logic                 r_burst_err, r_wr_err, r_past_top, r_prio_rd, r_rd_done;
   logic                 r_rvalid, r_rlast, r_rerr, r_rok;
   logic [DATA_W-1:0]    r_rd_word;
   logic [DATA_W-1:0]    r_mem [0:(1<<DEPTH_LOG2)-1];

   logic                 w_gnt_rd, w_gnt_wr, w_w_hs, w_rd_en, w_beat_last;
   logic                 w_hi_nz, w_oor;
   logic [DEPTH_LOG2-1:0] w_idx;

   function automatic logic f_burst_bad(input logic [1:0] burst, input logic [7:0] len,
                                        input logic [2:0] size);
      logic bad;
      bad = (size > 3'(LSB)) || (burst == 2'd3);
      if (burst == BURST_WRAP)
         bad = bad || !(WRAP_EN && (len inside {8'd1, 8'd3, 8'd7, 8'd15}));
      return bad;
   endfunction

   function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst,
                                                     input logic [7:0] len);
      logic [ADDR_W-1:0] incr, bound, nxt;
      incr  = ADDR_W'(1) << size;
      bound = ADDR_W'({1'b0, len} + 9'd1) << size;
      nxt   = addr;
      if (burst == BURST_INCR)
         nxt = (addr & ~(incr - ADDR_W'(1))) + incr;
      else if (WRAP_EN && burst == BURST_WRAP)
         nxt = (addr & ~(bound - ADDR_W'(1))) | ((addr + incr) & (bound - ADDR_W'(1)));
      return nxt;
   endfunction

   // Once a burst leaves the array it stays out, even if ADDR_W arithmetic wraps to 0.
   generate
      if (ADDR_W > IDX_HI) begin : g_hi
         assign w_hi_nz = |r_addr[ADDR_W-1:IDX_HI];
      end else begin : g_nohi
         assign w_hi_nz = 1'b0;
      end
   endgenerate

   assign w_oor       = w_hi_nz || r_past_top;
   assign w_idx       = r_addr[IDX_HI-1:LSB];
   assign w_beat_last = (r_cnt == r_len);
   assign w_gnt_rd    = arvalid && (!awvalid || r_prio_rd);
   assign w_gnt_wr    = awvalid && !w_gnt_rd;
   assign w_w_hs      = wvalid && wready;
   assign w_rd_en     = (r_state == S_RD) && !r_rd_done && (!r_rvalid || rready);

   assign bid         = r_id;
   assign bresp       = r_wr_err ? RESP_SLVERR : RESP_OKAY;
   assign rid         = r_id;
   assign rdata       = r_rok ? r_rd_word : '0;
   assign rresp       = r_rerr ? RESP_SLVERR : RESP_OKAY;
   assign rlast       = r_rlast;
   assign rvalid      = r_rvalid;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      awready = 1'b0;
      arready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            awready = w_gnt_wr;
            arready = w_gnt_rd;
            if (w_gnt_rd)      w_next = S_RD;
            else if (w_gnt_wr) w_next = S_WR;
         end
         S_WR: begin
            wready = 1'b1;
            if (wvalid && w_beat_last) w_next = S_WR_RESP;
         end
         S_WR_RESP: begin
            bvalid = 1'b1;
            if (bready) w_next = S_IDLE;
         end
         S_RD: begin
            if (r_rvalid && rready && r_rlast) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id        <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_burst_err <= 1'b0;
         r_wr_err    <= 1'b0;
         r_past_top  <= 1'b0;
         r_prio_rd   <= 1'b1;
         r_rd_done   <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rlast     <= 1'b0;
         r_rerr      <= 1'b0;
         r_rok       <= 1'b0;
      end else begin
         if (r_state == S_IDLE && (w_gnt_rd || w_gnt_wr)) begin
            r_cnt      <= '0;
            r_wr_err   <= 1'b0;
            r_past_top <= 1'b0;
            r_rd_done  <= 1'b0;
            r_prio_rd  <= !w_gnt_rd;
            if (w_gnt_rd) begin
               r_id        <= arid;
               r_addr      <= araddr;
               r_len       <= arlen;
               r_size      <= arsize;
               r_burst     <= arburst;
               r_burst_err <= f_burst_bad(arburst, arlen, arsize);
            end else begin
               r_id        <= awid;
               r_addr      <= awaddr;
               r_len       <= awlen;
               r_size      <= awsize;
               r_burst     <= awburst;
               r_burst_err <= f_burst_bad(awburst, awlen, awsize);
            end
         end

         if (w_w_hs || w_rd_en) begin
            r_cnt      <= r_cnt + 8'd1;
            r_addr     <= f_next_addr(r_addr, r_size, r_burst, r_len);
            r_past_top <= r_past_top || w_hi_nz;
         end

         if (w_w_hs && (r_burst_err || w_oor || (wlast != w_beat_last)))
            r_wr_err <= 1'b1;

         if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rlast  <= w_beat_last;
            r_rerr   <= r_burst_err || w_oor;
            r_rok    <= !(r_burst_err || w_oor);
            if (w_beat_last) r_rd_done <= 1'b1;
         end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // Array port: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_w_hs && !r_burst_err && !w_oor) begin
         for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) r_mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      if (w_rd_en) r_rd_word <= r_mem[w_idx];
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (default 64-bit, 32 KiB array).
`timescale 1ns/1ps
module tb_axi_mem_slave;

   localparam int DATA_W = 64;
   localparam logic [1:0] B_FIXED = 2'd0, B_INCR = 2'd1, B_WRAP = 2'd2, B_RSVD = 2'd3;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp, dbg_state;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [63:0] wdata, rdata;

   int n_checks = 0;
   int n_errors = 0;
   int r_first_idx;
   logic [DATA_W-1:0] wdata_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [1:0]        exp_resp_q[$];
   logic [3:0]        got_bid;
   logic [1:0]        got_bresp;

   axi_mem_slave dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rd(input logic [63:0] d, input logic [1:0] r);
      exp_q.push_back(d);
      exp_resp_q.push_back(r);
   endtask

   // All drivers are entered on a falling edge and return on a falling edge.
   task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      bit got;
      got = 1'b0;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      for (int n = 0; n < 100 && !got; n++) begin
         #1 got = awready;
         @(negedge clk);
      end
      awvalid = 1'b0;
      if (!got) check_val("aw_timeout", 0, 1);
   endtask

   task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      bit got;
      got = 1'b0;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      for (int n = 0; n < 100 && !got; n++) begin
         #1 got = arready;
         @(negedge clk);
      end
      arvalid = 1'b0;
      if (!got) check_val("ar_timeout", 0, 1);
   endtask

   task automatic w_send(input int n_beats, input logic [7:0] strb, input int last_at);
      bit got;
      for (int i = 0; i < n_beats; i++) begin
         got = 1'b0;
         wdata = wdata_q.pop_front(); wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
         for (int n = 0; n < 100 && !got; n++) begin
            #1 got = wready;
            @(negedge clk);
         end
         if (!got) check_val("w_timeout", 0, 1);
      end
      wvalid = 1'b0; wlast = 1'b0;
      got = 1'b0; bready = 1'b1;
      for (int n = 0; n < 100 && !got; n++) begin
         #1;
         if (bvalid) begin
            got = 1'b1; got_bid = bid; got_bresp = bresp;
         end
         @(negedge clk);
      end
      bready = 1'b0;
      if (!got) check_val("b_timeout", 0, 1);
   endtask

   task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] strb, input int last_at);
      aw_hs(id, addr, len, 3'd3, burst);
      w_send(int'(len) + 1, strb, last_at);
   endtask

   task automatic r_collect(input int n_beats, input logic [3:0] id, input bit toggle);
      int beats;
      bit stall;
      logic [63:0] prev;
      beats = 0; stall = 1'b0; prev = '0;
      r_first_idx = -1;
      rready = 1'b1;
      for (int n = 0; n < 200 && beats < n_beats; n++) begin
         #1;
         if (stall) begin
            check_val("r_hold_valid", rvalid, 1);
            check_val("r_stable", rdata, prev);
            stall = 1'b0;
         end
         if (rvalid && r_first_idx < 0) r_first_idx = n;
         if (rvalid && rready) begin
            check_val("r_data", rdata, exp_q.pop_front());
            check_val("r_resp", rresp, exp_resp_q.pop_front());
            check_val("r_last", rlast, beats == n_beats - 1);
            check_val("r_id", rid, id);
            beats++;
         end else if (rvalid) begin
            stall = 1'b1; prev = rdata;
         end
         @(negedge clk);
         if (toggle) rready = !rready;
      end
      rready = 1'b0;
      if (beats < n_beats) check_val("r_timeout", beats, n_beats);
   endtask

   task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
      ar_hs(id, addr, len, size, burst);
      r_collect(int'(len) + 1, id, toggle);
   endtask

   initial begin
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_ctrl", {awready, arready, wready, bvalid, rvalid, rlast}, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_resp_id", {bresp, rresp, bid, rid}, 0);
      check_val("rst_state", dbg_state, 0);
      @(negedge clk);

      // Single write then read, with read latency.
      wdata_q.push_back(64'h1122334455667788);
      wr_burst(4'h5, 32'h10, 8'd0, B_INCR, 8'hFF, 0);
      check_val("t1_bid", got_bid, 4'h5);
      check_val("t1_bresp", got_bresp, OKAY);
      push_rd(64'h1122334455667788, OKAY);
      rd_burst(4'h3, 32'h10, 8'd0, 3'd3, B_INCR, 1'b0);
      check_val("t1_latency", r_first_idx, 1);

      // INCR burst, read back under rready toggling.
      for (int i = 0; i < 4; i++) wdata_q.push_back(64'hA0 + 64'(i));
      wr_burst(4'h1, 32'h100, 8'd3, B_INCR, 8'hFF, 3);
      check_val("t2_bresp", got_bresp, OKAY);
      for (int i = 0; i < 4; i++) push_rd(64'hA0 + 64'(i), OKAY);
      rd_burst(4'h2, 32'h100, 8'd3, 3'd3, B_INCR, 1'b1);

      // Byte strobes.
      wdata_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      wr_burst(4'h0, 32'h20, 8'd0, B_INCR, 8'hFF, 0);
      wdata_q.push_back(64'h0);
      wr_burst(4'h0, 32'h20, 8'd0, B_INCR, 8'h0F, 0);
      push_rd(64'hFFFF_FFFF_0000_0000, OKAY);
      rd_burst(4'h4, 32'h20, 8'd0, 3'd3, B_INCR, 1'b0);

      // Simultaneous AW/AR after a write: read wins, then the write proceeds.
      wdata_q.push_back(64'h4444_0000_0000_0044);
      wr_burst(4'h6, 32'h40, 8'd0, B_INCR, 8'hFF, 0);
      awid = 4'h9; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd3; awburst = B_INCR; awvalid = 1'b1;
      arid = 4'hA; araddr = 32'h40; arlen = 8'd0; arsize = 3'd3; arburst = B_INCR; arvalid = 1'b1;
      #1;
      check_val("t4_arready", arready, 1);
      check_val("t4_awready", awready, 0);
      @(negedge clk);
      arvalid = 1'b0;
      #1 check_val("t4_aw_blocked", awready, 0);
      @(negedge clk);
      push_rd(64'h4444_0000_0000_0044, OKAY);
      r_collect(1, 4'hA, 1'b0);
      wdata_q.push_back(64'h5555_0000_0000_0055);
      aw_hs(4'h9, 32'h40, 8'd0, 3'd3, B_INCR);
      w_send(1, 8'hFF, 0);
      check_val("t4_bid", got_bid, 4'h9);
      push_rd(64'h5555_0000_0000_0055, OKAY);
      rd_burst(4'hB, 32'h40, 8'd0, 3'd3, B_INCR, 1'b0);

      // Top of array, protocol and size errors.
      wdata_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
      wr_burst(4'h1, 32'h7FF8, 8'd0, B_INCR, 8'hFF, 0);
      check_val("t5_top_wr", got_bresp, OKAY);
      wdata_q.push_back(64'h5A5A_5A5A_5A5A_5A5A);
      wr_burst(4'h1, 32'h18, 8'd0, B_INCR, 8'hFF, 0);
      push_rd(64'hDEAD_BEEF_0BAD_F00D, OKAY);
      push_rd(64'h0, SLVERR);
      rd_burst(4'h2, 32'h7FF8, 8'd1, 3'd3, B_INCR, 1'b0);
      for (int i = 0; i < 4; i++) wdata_q.push_back(64'hB0 + 64'(i));
      wr_burst(4'h3, 32'h200, 8'd3, B_INCR, 8'hFF, 1);
      check_val("t5_early_wlast", got_bresp, SLVERR);
      wdata_q.push_back(64'h77);
      wr_burst(4'h3, 32'h8000, 8'd0, B_INCR, 8'hFF, 0);
      check_val("t5_oor_wr", got_bresp, SLVERR);
      wdata_q.push_back(64'h66);
      wr_burst(4'h3, 32'h18, 8'd0, B_RSVD, 8'hFF, 0);
      check_val("t5_rsvd_wr", got_bresp, SLVERR);
      push_rd(64'h5A5A_5A5A_5A5A_5A5A, OKAY);
      rd_burst(4'h4, 32'h18, 8'd0, 3'd3, B_INCR, 1'b0);
      push_rd(64'h0, SLVERR);
      rd_burst(4'h4, 32'h10, 8'd0, 3'd4, B_INCR, 1'b0);

      // FIXED burst keeps hitting one word.
      wdata_q.push_back(64'h1111);
      wdata_q.push_back(64'h2222);
      wr_burst(4'h5, 32'h300, 8'd1, B_FIXED, 8'hFF, 1);
      check_val("fixed_bresp", got_bresp, OKAY);
      push_rd(64'h2222, OKAY);
      push_rd(64'h2222, OKAY);
      rd_burst(4'h5, 32'h300, 8'd1, 3'd3, B_FIXED, 1'b0);

      // Reset in the middle of a read burst.
      ar_hs(4'h7, 32'h100, 8'd7, 3'd3, B_INCR);
      rready = 1'b1;
      repeat (3) @(negedge clk);
      #1 check_val("t6_beat2_valid", rvalid, 1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_val("t6_rvalid", rvalid, 0);
      check_val("t6_state", dbg_state, 0);
      rready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_rd(64'h1122334455667788, OKAY);
      rd_burst(4'h8, 32'h10, 8'd0, 3'd3, B_INCR, 1'b0);

`ifdef AXI_MEM_WRAP_EN
      for (int i = 0; i < 4; i++) wdata_q.push_back(64'hC0 + 64'(i));
      wr_burst(4'h2, 32'h18, 8'd3, B_WRAP, 8'hFF, 3);
      check_val("wrap_bresp", got_bresp, OKAY);
      push_rd(64'hC1, OKAY);
      push_rd(64'hC2, OKAY);
      push_rd(64'hC3, OKAY);
      push_rd(64'hC0, OKAY);
      rd_burst(4'h2, 32'h0, 8'd3, 3'd3, B_INCR, 1'b0);
      for (int i = 0; i < 4; i++) push_rd(64'hC0 + 64'(i), OKAY);
      rd_burst(4'h2, 32'h18, 8'd3, 3'd3, B_WRAP, 1'b0);
      for (int i = 0; i < 3; i++) wdata_q.push_back(64'hE0);
      wr_burst(4'h2, 32'h18, 8'd2, B_WRAP, 8'hFF, 2);
      check_val("wrap_badlen", got_bresp, SLVERR);
`else
      for (int i = 0; i < 4; i++) wdata_q.push_back(64'hC0 + 64'(i));
      wr_burst(4'h2, 32'h18, 8'd3, B_WRAP, 8'hFF, 3);
      check_val("wrap_rsvd_bresp", got_bresp, SLVERR);
      push_rd(64'h5A5A_5A5A_5A5A_5A5A, OKAY);
      rd_burst(4'h2, 32'h18, 8'd0, 3'd3, B_INCR, 1'b0);
      for (int i = 0; i < 4; i++) push_rd(64'h0, SLVERR);
      rd_burst(4'h2, 32'h18, 8'd3, 3'd3, B_WRAP, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
